stream_vrf_writer: RTL and testbench

STREAM_VRF_WRITER -- requirements
Module: stream_vrf_writer

---
 rtl/vec_stream_pkg.sv | 14 +
 rtl/stream_vrf_writer.sv | 133 +++++++++++++
 tb/tb_stream_vrf_writer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_stream_pkg.sv
// Shared types for the vector stream blocks: drain FSM states and element index.
package vec_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Wide enough to count up to VLEN_MAX inclusive for any supported VLEN_MAX.
  localparam int unsigned ELEM_IDX_W = 16;
  typedef logic [ELEM_IDX_W-1:0] elem_idx_t;

endpackage

// File: rtl/stream_vrf_writer.sv
// Drains vl elements from a val/rdy stream into vector register vd, one write per beat.
// Optional per-element write mask enabled by defining STREAM_VRF_WRITER_MASK_EN.
module stream_vrf_writer
  import vec_stream_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned VLEN_MAX = 16,
  parameter int unsigned NREGS    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(NREGS)-1:0]    vd,
  input  logic [$clog2(VLEN_MAX):0]   vl,
`ifdef STREAM_VRF_WRITER_MASK_EN
  input  logic [VLEN_MAX-1:0]         vmask,
`endif
  input  logic [WIDTH-1:0]            recv_msg,
  input  logic                        recv_val,
  output logic                        recv_rdy,
  output logic                        wen,
  output logic [$clog2(NREGS)-1:0]    wreg,
  output logic [$clog2(VLEN_MAX)-1:0] welem,
  output logic [WIDTH-1:0]            wdata,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned EW = $clog2(VLEN_MAX);
  localparam int unsigned LW = EW + 1;

  state_t          state_q, state_d;
  logic [RW-1:0]   vd_q;
  logic [LW-1:0]   vl_q;
  logic [LW-1:0]   vl_clamped;
  elem_idx_t       cnt_q;
  logic            take_start;
  logic            accept;
  logic            last_beat;
  logic            write_beat;

`ifdef STREAM_VRF_WRITER_MASK_EN
  logic [VLEN_MAX-1:0] mask_q;
`endif

  assign vl_clamped = (vl > LW'(VLEN_MAX)) ? LW'(VLEN_MAX) : vl;
  assign take_start = (state_q == IDLE) && start;
  assign accept     = recv_rdy && recv_val;
  assign last_beat  = accept && ((cnt_q + elem_idx_t'(1)) == elem_idx_t'(vl_q));

`ifdef STREAM_VRF_WRITER_MASK_EN
  // Masked-off beats are still consumed and counted; only the write is dropped.
  assign write_beat = accept && mask_q[cnt_q[EW-1:0]];
`else
  assign write_beat = accept;
`endif

  always_comb begin
    state_d  = state_q;
    recv_rdy = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = (vl_clamped == '0) ? FINISH : DRAIN;
        end
      end
      DRAIN: begin
        recv_rdy = 1'b1;
        if (last_beat) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vd_q    <= '0;
      vl_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take_start) begin
        vd_q  <= vd;
        vl_q  <= vl_clamped;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + elem_idx_t'(1);
      end
    end
  end

`ifdef STREAM_VRF_WRITER_MASK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else if (take_start) begin
      mask_q <= vmask;
    end
  end
`endif

  // Write port is registered: wen pulses the cycle after the handshake,
  // address/data fields hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen   <= 1'b0;
      wreg  <= '0;
      welem <= '0;
      wdata <= '0;
    end else begin
      wen <= write_beat;
      if (write_beat) begin
        wreg  <= vd_q;
        welem <= cnt_q[EW-1:0];
        wdata <= recv_msg;
      end
    end
  end

endmodule

// File: tb/tb_stream_vrf_writer.sv
// Directed bench for stream_vrf_writer (WIDTH=32, VLEN_MAX=16, NREGS=32).
module tb_stream_vrf_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  vd;
  logic [4:0]  vl;
`ifdef STREAM_VRF_WRITER_MASK_EN
  logic [15:0] vmask;
`endif
  logic [31:0] recv_msg;
  logic        recv_val;
  logic        recv_rdy;
  logic        wen;
  logic [4:0]  wreg;
  logic [3:0]  welem;
  logic [31:0] wdata;
  logic        busy;
  logic        done;

  int total;
  int bad;

  stream_vrf_writer #(
    .WIDTH   (32),
    .VLEN_MAX(16),
    .NREGS   (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .vd      (vd),
    .vl      (vl),
`ifdef STREAM_VRF_WRITER_MASK_EN
    .vmask   (vmask),
`endif
    .recv_msg(recv_msg),
    .recv_val(recv_val),
    .recv_rdy(recv_rdy),
    .wen     (wen),
    .wreg    (wreg),
    .welem   (welem),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, done, recv_rdy, wen} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0000", {busy, done, recv_rdy, wen});
    end
    total++;
    if ({wreg, welem, wdata} !== 41'd0) begin
      bad++;
      $display("FAIL reset_port got wreg=%0d welem=%0d wdata=%h want 0/0/0", wreg, welem, wdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_stream();
    start = 1'b1; vd = 5'd5; vl = 5'd4; recv_val = 1'b1; recv_msg = 32'hA0;
    tick();
    start = 1'b0;
    total++;
    if ({busy, done, recv_rdy, wen} !== 4'b1010) begin
      bad++;
      $display("FAIL full_first_drain got=%b want=1010", {busy, done, recv_rdy, wen});
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      recv_msg = 32'hA0 + 32'(k) + 32'd1;
      total++;
      if ({wen, done} !== {1'b1, (k == 3)}) begin
        bad++;
        $display("FAIL full_wen_done k=%0d got=%b want=%b", k, {wen, done}, {1'b1, (k == 3)});
      end
      total++;
      if ({wreg, welem, wdata} !== {5'd5, 4'(k), 32'hA0 + 32'(k)}) begin
        bad++;
        $display("FAIL full_write k=%0d got wreg=%0d welem=%0d wdata=%h want 5/%0d/%h",
                 k, wreg, welem, wdata, k, 32'hA0 + 32'(k));
      end
    end
    recv_val = 1'b0;
    tick();
    total++;
    if ({busy, done, recv_rdy, wen} !== 4'b0000) begin
      bad++;
      $display("FAIL full_back_idle got=%b want=0000", {busy, done, recv_rdy, wen});
    end
  endtask

  task automatic test_toggle_val();
    logic [4:0] pat;
    int n;
    pat = 5'b10101;
    n = 0;
    start = 1'b1; vd = 5'd7; vl = 5'd3; recv_val = 1'b0; recv_msg = 32'hB0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      recv_val = pat[i];
      recv_msg = 32'hB0 + 32'(n);
      #1;
      total++;
      if (recv_rdy !== 1'b1) begin
        bad++;
        $display("FAIL toggle_rdy i=%0d got=%b want=1", i, recv_rdy);
      end
      tick();
      if (pat[i]) n++;
      total++;
      if ({wen, done} !== {pat[i], (i == 4)}) begin
        bad++;
        $display("FAIL toggle_wen_done i=%0d got=%b want=%b", i, {wen, done}, {pat[i], (i == 4)});
      end
      if (pat[i]) begin
        total++;
        if ({wreg, welem, wdata} !== {5'd7, 4'(n - 1), 32'hB0 + 32'(n - 1)}) begin
          bad++;
          $display("FAIL toggle_write i=%0d got wreg=%0d welem=%0d wdata=%h want 7/%0d/%h",
                   i, wreg, welem, wdata, n - 1, 32'hB0 + 32'(n - 1));
        end
      end
    end
    recv_val = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL toggle_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_zero_len();
    start = 1'b1; vd = 5'd1; vl = 5'd0; recv_val = 1'b1; recv_msg = 32'hDEAD;
    tick();
    start = 1'b0;
    total++;
    if ({busy, done, recv_rdy, wen} !== 4'b1100) begin
      bad++;
      $display("FAIL zero_finish got=%b want=1100", {busy, done, recv_rdy, wen});
    end
    tick();
    total++;
    if ({busy, done, recv_rdy, wen} !== 4'b0000) begin
      bad++;
      $display("FAIL zero_idle got=%b want=0000", {busy, done, recv_rdy, wen});
    end
    recv_val = 1'b0;
  endtask

  task automatic test_clamp_and_ignore();
    start = 1'b1; vd = 5'd3; vl = 5'd20; recv_val = 1'b1; recv_msg = 32'hC0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        start = 1'b1; vd = 5'd9; vl = 5'd2;
      end
      tick();
      start = 1'b0;
      recv_msg = 32'hC0 + 32'(k) + 32'd1;
      total++;
      if ({wen, done, wreg, welem} !== {1'b1, (k == 15), 5'd3, 4'(k)}) begin
        bad++;
        $display("FAIL clamp_write k=%0d got wen=%b done=%b wreg=%0d welem=%0d want 1/%0b/3/%0d",
                 k, wen, done, wreg, welem, (k == 15), k);
      end
    end
    tick();
    total++;
    if ({busy, done, recv_rdy, wen} !== 4'b0000) begin
      bad++;
      $display("FAIL clamp_idle got=%b want=0000", {busy, done, recv_rdy, wen});
    end
    recv_val = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    start = 1'b1; vd = 5'd2; vl = 5'd4; recv_val = 1'b1; recv_msg = 32'hE0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      recv_msg = 32'hE0 + 32'(k) + 32'd1;
      total++;
      if ({wen, welem} !== {1'b1, 4'(k)}) begin
        bad++;
        $display("FAIL abort_pre k=%0d got wen=%b welem=%0d want 1/%0d", k, wen, welem, k);
      end
    end
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, recv_rdy, wen} !== 4'b0000) begin
      bad++;
      $display("FAIL abort_immediate got=%b want=0000", {busy, done, recv_rdy, wen});
    end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({busy, done, recv_rdy, wen} !== 4'b0000) begin
      bad++;
      $display("FAIL abort_after got=%b want=0000", {busy, done, recv_rdy, wen});
    end
    start = 1'b1; vd = 5'd4; vl = 5'd2; recv_msg = 32'hF0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      recv_msg = 32'hF0 + 32'(k) + 32'd1;
      total++;
      if ({wen, done, wreg, welem, wdata} !== {1'b1, (k == 1), 5'd4, 4'(k), 32'hF0 + 32'(k)}) begin
        bad++;
        $display("FAIL abort_restart k=%0d got wen=%b done=%b wreg=%0d welem=%0d wdata=%h",
                 k, wen, done, wreg, welem, wdata);
      end
    end
    recv_val = 1'b0;
    tick();
  endtask

`ifdef STREAM_VRF_WRITER_MASK_EN
  task automatic test_mask();
    logic [3:0] m;
    m = 4'b0101;
    vmask = 16'b0101;
    start = 1'b1; vd = 5'd6; vl = 5'd4; recv_val = 1'b1; recv_msg = 32'h10;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      recv_msg = 32'h10 + 32'(k) + 32'd1;
      total++;
      if ({wen, done} !== {m[k], (k == 3)}) begin
        bad++;
        $display("FAIL mask_wen_done k=%0d got=%b want=%b", k, {wen, done}, {m[k], (k == 3)});
      end
      if (m[k]) begin
        total++;
        if ({welem, wdata} !== {4'(k), 32'h10 + 32'(k)}) begin
          bad++;
          $display("FAIL mask_write k=%0d got welem=%0d wdata=%h", k, welem, wdata);
        end
      end
    end
    recv_val = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mask_idle busy got=%b want=0", busy);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    vd = '0;
    vl = '0;
`ifdef STREAM_VRF_WRITER_MASK_EN
    vmask = '0;
`endif
    recv_msg = '0;
    recv_val = 1'b0;
    test_reset();
    test_full_stream();
    test_toggle_val();
    test_zero_len();
    test_clamp_and_ignore();
    test_reset_mid_drain();
`ifdef STREAM_VRF_WRITER_MASK_EN
    test_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
